// File: rtl/dsp_mac_sequencer_pkg.sv
// Shared definitions for the DSP MAC sequencer.
// Holds the sequencer FSM state type, the OPMODE words sent to the DSP slice,
// the operand/accumulator widths and the default operand-to-P latency.
package dsp_mac_sequencer_pkg;

  localparam int DATA_W      = 18;
  localparam int ACC_W       = 48;
  localparam int LATENCY_DEF = 3;

  // OPMODE words: X select in [1:0], Z select in [3:2].
  localparam logic [7:0] OPM_FIRST = 8'h01;  // X=M, Z=0: start a fresh sum
  localparam logic [7:0] OPM_ACC   = 8'h09;  // X=M, Z=P: accumulate
  localparam logic [7:0] OPM_HOLD  = 8'h08;  // X=0, Z=P: keep P unchanged
  localparam logic [7:0] OPM_RST   = 8'h00;  // X=0, Z=0: slice output forced to 0

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/dsp_mac_sequencer_if.sv
// Operand/result stream bundle of the DSP MAC sequencer.
// Operand side: in_valid/in_ready handshake, in_a/in_b unsigned operands,
// in_last marking the final pair of a job.
// Result side: res_valid/res_ready handshake, res_data sum of products,
// res_count saturating pair count, res_carry sticky carry-out.
// The slave modport is the sequencer; the master modport is its user.
interface dsp_mac_sequencer_if #(
  parameter int CNT_W = 10
);
  import dsp_mac_sequencer_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic              in_last;

  logic              res_valid;
  logic              res_ready;
  logic [ACC_W-1:0]  res_data;
  logic [CNT_W-1:0]  res_count;
  logic              res_carry;

  modport master (
    output in_valid, in_a, in_b, in_last, res_ready,
    input  in_ready, res_valid, res_data, res_count, res_carry
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, res_ready,
    output in_ready, res_valid, res_data, res_count, res_carry
  );

endinterface

// File: rtl/dsp_seq_delay.sv
// OPMODE lag and drain counter for the DSP MAC sequencer.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   slot_opm    : OPMODE belonging to the current operand slot
//   opm_p1      : the same OPMODE one cycle later (drives the slice OPMODE port)
//   drain_load  : the final pair of a job is being accepted this cycle
//   drain_en    : sequencer is waiting for the final sum
//   drain_done  : dsp_p holds the final sum this cycle
module dsp_seq_delay
  import dsp_mac_sequencer_pkg::*;
#(
  parameter int LATENCY = LATENCY_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] slot_opm,
  output logic [7:0] opm_p1,
  input  logic       drain_load,
  input  logic       drain_en,
  output logic       drain_done
);

  localparam int CW = $clog2(LATENCY + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_dec;

  // The counter starts at LATENCY when the final pair is accepted and
  // steps down once per drain cycle; the edge that takes it to zero is the
  // one at which dsp_p carries the product of that final pair.
  assign cnt_dec    = cnt_q - CW'(1);
  assign drain_done = drain_en && (cnt_dec == '0);

  // ---- stage p1: OPMODE lags its operand slot by one cycle ----
  always_ff @(posedge clk) begin
    if (rst) begin
      opm_p1 <= OPM_RST;
      cnt_q  <= '0;
    end else begin
      opm_p1 <= slot_opm;
      if (drain_load) begin
        cnt_q <= CW'(LATENCY);
      end else if (drain_en && (cnt_q != '0)) begin
        cnt_q <= cnt_dec;
      end
    end
  end

endmodule

// File: rtl/dsp_mac_sequencer.sv
// DSP MAC sequencer: streams unsigned operand pairs into an external DSP
// slice (A1REG, MREG, PREG, OPMODEREG), steers its OPMODE so the pairs of a
// job are summed in P, and presents the final sum with a saturating pair
// count and a sticky carry flag.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   bus (slave)       : operand stream in, result stream out
//   dsp_a, dsp_b      : operands to the slice A/B ports (zero on empty slots)
//   dsp_opmode        : slice OPMODE, one cycle behind its operand slot
//   dsp_p             : slice P output
//   dsp_carryout      : slice CARRYOUT
module dsp_mac_sequencer
  import dsp_mac_sequencer_pkg::*;
#(
  parameter int LATENCY = LATENCY_DEF,
  parameter int CNT_W   = 10
) (
  input  logic              clk,
  input  logic              rst,
  dsp_mac_sequencer_if.slave bus,
  output logic [DATA_W-1:0] dsp_a,
  output logic [DATA_W-1:0] dsp_b,
  output logic [7:0]        dsp_opmode,
  input  logic [ACC_W-1:0]  dsp_p,
  input  logic              dsp_carryout
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_t            state_q;
  state_t            state_n;
  logic              accept;
  logic              first_slot;
  logic              slot_in_job;
  logic              drain_done;
  logic [7:0]        slot_opm;
  logic [LATENCY-1:0] job_vld_p;
  logic [ACC_W-1:0]  res_data_q;
  logic [CNT_W-1:0]  count_q;
  logic              carry_q;

  // No pair is taken while reset is asserted, so nothing leaks onto the
  // slice ports in the cycle that reset discards.
  assign bus.in_ready = ((state_q == IDLE) || (state_q == ISSUE)) && !rst;
  assign accept       = bus.in_valid && bus.in_ready;
  assign first_slot   = (state_q == IDLE);

  // Gaps inside ISSUE still belong to the job: P is held but its update
  // (with whatever CARRYOUT it reports) is part of this job's window.
  assign slot_in_job  = accept || (state_q == ISSUE);

  // ---- stage p0: operands go straight to the slice A/B registers ----
  assign dsp_a = accept ? bus.in_a : '0;
  assign dsp_b = accept ? bus.in_b : '0;

  always_comb begin
    state_n  = state_q;
    slot_opm = OPM_HOLD;
    if (accept) begin
      slot_opm = first_slot ? OPM_FIRST : OPM_ACC;
    end
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_n = bus.in_last ? DRAIN : ISSUE;
        end
      end
      ISSUE: begin
        if (accept && bus.in_last) begin
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_done) begin
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (bus.res_valid && bus.res_ready) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  // ---- stage p1: OPMODE register feed and drain counter ----
  dsp_seq_delay #(
    .LATENCY (LATENCY)
  ) u_delay (
    .clk        (clk),
    .rst        (rst),
    .slot_opm   (slot_opm),
    .opm_p1     (dsp_opmode),
    .drain_load (accept && bus.in_last),
    .drain_en   (state_q == DRAIN),
    .drain_done (drain_done)
  );

  // ---- stages p1..pLATENCY: job membership travels with the slice pipe ----
  // job_vld_p[LATENCY-1] is set in exactly the cycles whose dsp_p/CARRYOUT
  // come from a slot of the current job.
  always_ff @(posedge clk) begin
    if (rst) begin
      job_vld_p <= '0;
    end else begin
      job_vld_p[0] <= slot_in_job;
      for (int i = 1; i < LATENCY; i++) begin
        job_vld_p[i] <= job_vld_p[i-1];
      end
    end
  end

  // ---- result registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      res_data_q <= '0;
      count_q    <= '0;
      carry_q    <= 1'b0;
    end else begin
      if ((state_q == DRAIN) && drain_done) begin
        res_data_q <= dsp_p;
      end
      if (accept) begin
        count_q <= first_slot ? CNT_W'(1) : sat_inc(count_q);
      end
      if (accept && first_slot) begin
        carry_q <= 1'b0;
      end else if (job_vld_p[LATENCY-1]) begin
        carry_q <= carry_q | dsp_carryout;
      end
    end
  end

  assign bus.res_valid = (state_q == HOLD);
  assign bus.res_data  = res_data_q;
  assign bus.res_count = count_q;
  assign bus.res_carry = carry_q;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Self-checking bench for dsp_mac_sequencer. A behavioural DSP slice
// (A1/B1 regs, M reg, OPMODE reg, P/CARRYOUT regs) closes the loop; a
// job-level model predicts handshakes, slice ports and results every cycle.
module tb_dsp_mac_sequencer;
  import dsp_mac_sequencer_pkg::*;

  localparam int LAT = 3;
  localparam int CW  = 10;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dsp_mac_sequencer_if #(.CNT_W(CW)) bus();

  logic [17:0] dsp_a, dsp_b;
  logic [7:0]  dsp_opmode;
  logic [47:0] dsp_p;
  logic        dsp_carryout;

  dsp_mac_sequencer #(.LATENCY(LAT), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .dsp_a        (dsp_a),
    .dsp_b        (dsp_b),
    .dsp_opmode   (dsp_opmode),
    .dsp_p        (dsp_p),
    .dsp_carryout (dsp_carryout)
  );

  // Behavioural DSP slice
  logic [17:0] sl_a1 = '0, sl_b1 = '0;
  logic [35:0] sl_m = '0;
  logic [7:0]  sl_opm = '0;
  logic [47:0] sl_p = '0;
  logic        sl_c = 1'b0;
  logic [47:0] sl_x, sl_z;
  logic [48:0] sl_sum;

  always_comb begin
    sl_x   = (sl_opm[1:0] == 2'b01) ? {12'b0, sl_m} : 48'b0;
    sl_z   = (sl_opm[3:2] == 2'b10) ? sl_p : 48'b0;
    sl_sum = {1'b0, sl_x} + {1'b0, sl_z};
  end

  always @(posedge clk) begin
    sl_a1  <= dsp_a;
    sl_b1  <= dsp_b;
    sl_m   <= sl_a1 * sl_b1;
    sl_opm <= dsp_opmode;
    sl_p   <= sl_sum[47:0];
    sl_c   <= sl_sum[48];
  end

  assign dsp_p        = sl_p;
  assign dsp_carryout = sl_c;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Job-level model state
  bit          m_busy = 0;
  bit          m_rv   = 0;
  int          m_wait = 0;
  int          m_job_n = 0;
  logic [47:0] m_sum = '0;
  bit          m_carry = 0;
  logic [7:0]  m_opm = 8'h00;
  logic [47:0] e_data = '0;
  int          e_cnt = 0;
  bit          e_carry = 0;
  int          cyc = 0;
  int          last_acc_cyc = 0, lat_seen = 0, hs_cyc = 0, acc_cyc = 0;
  bit          prev_rv = 0;

  always @(negedge clk) begin : monitor
    logic        acc;
    bit          nb, nrv;
    logic [48:0] s;
    cyc++;
    if (rst) begin
      m_busy  = 0;
      m_rv    = 0;
      m_wait  = 0;
      m_job_n = 0;
      m_opm   = 8'h00;
    end else begin
      chk("in_ready", bus.in_ready, !m_busy);
      acc = bus.in_valid && !m_busy;
      chk("dsp_a", dsp_a, acc ? bus.in_a : 18'd0);
      chk("dsp_b", dsp_b, acc ? bus.in_b : 18'd0);
      chk("dsp_opmode", dsp_opmode, m_opm);
      chk("res_valid", bus.res_valid, m_rv);
      if (m_rv) begin
        chk("res_data", bus.res_data, e_data);
        chk("res_count", bus.res_count, e_cnt);
        chk("res_carry", bus.res_carry, e_carry);
      end
      if (bus.res_valid && !prev_rv) lat_seen = cyc - last_acc_cyc;
      if (bus.in_valid && bus.in_ready) acc_cyc = cyc;
      if (bus.res_valid && bus.res_ready) hs_cyc = cyc;

      nb  = m_busy;
      nrv = m_rv;
      if (m_busy && !m_rv) begin
        m_wait++;
        if (m_wait == LAT) nrv = 1;
      end
      if (m_rv && bus.res_ready) begin
        nrv = 0;
        nb  = 0;
      end
      m_opm = acc ? ((m_job_n == 0) ? 8'h01 : 8'h09) : 8'h08;
      if (acc) begin
        if (m_job_n == 0) begin
          m_sum   = '0;
          m_carry = 0;
        end
        s = {1'b0, m_sum} + ({31'b0, bus.in_a} * {31'b0, bus.in_b});
        m_sum   = s[47:0];
        m_carry = m_carry | s[48];
        m_job_n++;
        if (bus.in_last) begin
          nb      = 1;
          m_wait  = 0;
          e_data  = m_sum;
          e_cnt   = (m_job_n > CNT_MAX) ? CNT_MAX : m_job_n;
          e_carry = m_carry;
          m_job_n = 0;
          last_acc_cyc = cyc;
        end
      end
      m_busy = nb;
      m_rv   = nrv;
    end
    prev_rv = bus.res_valid;
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic send(input logic [17:0] a, input logic [17:0] b, input logic last);
    int g = 0;
    bus.in_a = a;
    bus.in_b = b;
    bus.in_last = last;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (!bus.in_ready) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic gap2();
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("gap_opmode", dsp_opmode, 8'h08);
    @(posedge clk); #1;
  endtask

  task automatic get_result(input int hold, input logic [47:0] xd, input int xc, input bit xcar);
    int g = 0;
    @(negedge clk);
    while (!bus.res_valid && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (!bus.res_valid) chk("result_timeout", 0, 1);
    chk("lit_data", bus.res_data, xd);
    chk("lit_count", bus.res_count, xc);
    chk("lit_carry", bus.res_carry, xcar);
    repeat (hold) begin
      @(posedge clk); #1;
    end
    if (hold > 0) begin
      @(negedge clk);
      chk("hold_valid", bus.res_valid, 1);
      chk("hold_data", bus.res_data, xd);
      chk("hold_in_ready", bus.in_ready, 0);
    end
    @(posedge clk); #1;
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_last   = 1'b0;
    bus.res_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_data", bus.res_data, 0);
    chk("rst_res_count", bus.res_count, 0);
    chk("rst_res_carry", bus.res_carry, 0);
    chk("rst_opmode", dsp_opmode, 8'h00);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_dsp_a", dsp_a, 0);
    @(posedge clk); #1;

    // Single pair
    send(18'd3, 18'd4, 1'b1);
    get_result(0, 48'd12, 1, 0);
    chk("single_latency", lat_seen, 4);

    // Four back-to-back pairs
    send(18'd1, 18'd1, 1'b0);
    send(18'd2, 18'd2, 1'b0);
    send(18'd3, 18'd3, 1'b0);
    send(18'd4, 18'd4, 1'b1);
    get_result(0, 48'd30, 4, 0);

    // Same pairs with two idle cycles between them
    send(18'd1, 18'd1, 1'b0);
    gap2();
    send(18'd2, 18'd2, 1'b0);
    gap2();
    send(18'd3, 18'd3, 1'b0);
    gap2();
    send(18'd4, 18'd4, 1'b1);
    get_result(0, 48'd30, 4, 0);

    // Result held back; next pair offered throughout drain and hold
    send(18'd7, 18'd8, 1'b1);
    bus.in_a = 18'd2;
    bus.in_b = 18'd5;
    bus.in_last = 1'b1;
    bus.in_valid = 1'b1;
    get_result(5, 48'd56, 1, 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    chk("accept_after_handshake", acc_cyc - hs_cyc, 1);
    get_result(0, 48'd10, 1, 0);

    // Reset in the middle of a job
    send(18'd1, 18'd1, 1'b0);
    send(18'd2, 18'd2, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_res_valid", bus.res_valid, 0);
    chk("midrst_opmode", dsp_opmode, 8'h00);
    chk("midrst_in_ready", bus.in_ready, 1);
    chk("midrst_count", bus.res_count, 0);
    @(posedge clk); #1;
    send(18'd5, 18'd6, 1'b1);
    get_result(0, 48'd30, 1, 0);

    // 1024 maximal pairs: count saturates, sum 2^46 - 2^29 + 2^10 fits in 48 bits
    for (int i = 0; i < 1024; i++) send(18'h3FFFF, 18'h3FFFF, (i == 1023));
    get_result(0, 48'd70368207307776, CNT_MAX, 0);

    // 4100 maximal pairs: accumulation wraps past 2^48
    for (int i = 0; i < 4100; i++) send(18'h3FFFF, 18'h3FFFF, (i == 4099));
    get_result(0, 48'd272728330244, CNT_MAX, 1);

    // Carry cleared at the start of the next job
    send(18'd1, 18'd2, 1'b1);
    get_result(0, 48'd2, 1, 0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
